// File: rtl/seq_pkg.sv
// Shared definitions for batch_run_sequencer.
//   state_t / St*  : FSM state encoding (IDLE, LAUNCH, WAIT, FIN)
//   timer_width()  : bits needed for a counter reaching max_count, minimum 1
//   TIMER_W        : WAIT-timer width for the default TIMEOUT
package seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StLaunch = 2'd1;
  localparam state_t StWait   = 2'd2;
  localparam state_t StFin    = 2'd3;

  // max(1, $clog2(max_count + 1)); 64-bit math so the +1 never overflows.
  function automatic int unsigned timer_width(input int unsigned max_count);
    if (max_count == 0) begin
      return 1;
    end
    return $clog2(64'(max_count) + 64'd1);
  endfunction

  localparam int unsigned DefaultTimeout = 1000000;
  localparam int unsigned TIMER_W        = timer_width(DefaultTimeout);

endpackage

// File: rtl/batch_run_sequencer_if.sv
// Bundle between the run controller, the sequencer and the `main` datapath.
//   Controller -> sequencer : go, abort, first_index, last_index
//   main -> sequencer       : finish
//   Sequencer -> main       : start, file_index
//   Sequencer -> controller : busy, done, jobs_done, jobs_timed_out, timeout_err
// master: controller/bench view; slave: sequencer view.
interface batch_run_sequencer_if #(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned CNT_W = 16
);

  logic             go;
  logic             abort;
  logic [IDX_W-1:0] first_index;
  logic [IDX_W-1:0] last_index;
  logic             finish;
  logic             start;
  logic [IDX_W-1:0] file_index;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] jobs_done;
  logic [CNT_W-1:0] jobs_timed_out;
  logic             timeout_err;

  modport master (
    output go, abort, first_index, last_index, finish,
    input  start, file_index, busy, done, jobs_done, jobs_timed_out, timeout_err
  );

  modport slave (
    input  go, abort, first_index, last_index, finish,
    output start, file_index, busy, done, jobs_done, jobs_timed_out, timeout_err
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear to 0 (wins over inc_i)
//   inc_i    : add one, sticking at all-ones
//   q_o      : registered count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != {WIDTH{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/batch_run_sequencer.sv
// Steps the `main` datapath through file indices first_index..last_index.
// Each job: start held for START_CYCLES cycles with file_index presented, then
// wait for finish (or a TIMEOUT-cycle timeout), then advance or finish the batch.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave view of batch_run_sequencer_if (controller and main signals)
// All outputs are registered.
module batch_run_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned IDX_W        = 10,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int unsigned CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst,
  batch_run_sequencer_if.slave  bus
);

  localparam int unsigned TimerW  = timer_width(TIMEOUT);
  localparam int unsigned LaunchW = timer_width(START_CYCLES);

  localparam bit                TimeoutEn  = (TIMEOUT != 0);
  localparam logic [TimerW-1:0] TimerLast  = TimeoutEn ? TimerW'(TIMEOUT - 1) : '0;
  localparam logic [LaunchW-1:0] LaunchLast = LaunchW'(START_CYCLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   file_index_q, file_index_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [LaunchW-1:0] lcnt_q, lcnt_d;

  logic clr_cnt;
  logic inc_done;
  logic inc_to;
  logic timeout_hit;

  assign timeout_hit = TimeoutEn && (timer_q == TimerLast);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    file_index_d = file_index_q;
    start_d      = start_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    timer_d      = timer_q;
    lcnt_d       = lcnt_q;
    clr_cnt      = 1'b0;
    inc_done     = 1'b0;
    inc_to       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          idx_d   = bus.first_index;
          last_d  = bus.last_index;
          clr_cnt = 1'b1;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          if (bus.first_index <= bus.last_index) begin
            state_d      = StLaunch;
            start_d      = 1'b1;
            file_index_d = bus.first_index;
            lcnt_d       = '0;
          end else begin
            state_d = StFin;
          end
        end
      end

      // finish is deliberately ignored here: it may still be high from the last job.
      StLaunch: begin
        if (bus.abort) begin
          state_d = StIdle;
          start_d = 1'b0;
          busy_d  = 1'b0;
        end else if (lcnt_q == LaunchLast) begin
          state_d = StWait;
          start_d = 1'b0;
          timer_d = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end

      // Priority: abort > finish > timeout.
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (bus.abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (bus.finish || timeout_hit) begin
          if (bus.finish) begin
            inc_done = 1'b1;
          end else begin
            inc_to = 1'b1;
            err_d  = 1'b1;
          end
          // Compare before incrementing so last = all-ones never wraps.
          if (idx_q == last_q) begin
            state_d = StFin;
          end else begin
            idx_d        = idx_q + 1'b1;
            file_index_d = idx_q + 1'b1;
            start_d      = 1'b1;
            lcnt_d       = '0;
            state_d      = StLaunch;
          end
        end
      end

      // done and the busy drop become visible together on the way back to IDLE.
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      last_q       <= '0;
      file_index_q <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      timer_q      <= '0;
      lcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      file_index_q <= file_index_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
      lcnt_q       <= lcnt_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_jobs_done (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (inc_done),
    .q_o   (bus.jobs_done)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_jobs_timed_out (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (inc_to),
    .q_o   (bus.jobs_timed_out)
  );

  assign bus.start       = start_q;
  assign bus.file_index  = file_index_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_batch_run_sequencer.sv
// Scoreboard bench for batch_run_sequencer: stimulus pushes expected start
// indices and end-of-batch results; a negedge monitor pops and compares.
module tb_batch_run_sequencer;

  localparam int unsigned IdxW        = 10;
  localparam int unsigned CntW        = 16;
  localparam int unsigned StartCycles = 2;
  localparam int unsigned Timeout     = 50;
  localparam int          FinDelay    = 30;

  typedef struct {
    int jobs;
    int tos;
    int err;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  batch_run_sequencer_if #(.IDX_W(IdxW), .CNT_W(CntW)) bus ();

  batch_run_sequencer #(
    .IDX_W        (IdxW),
    .START_CYCLES (StartCycles),
    .TIMEOUT      (Timeout),
    .CNT_W        (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int        exp_idx_q[$];
  done_exp_t exp_done_q[$];
  int        n_pass = 0;
  int        n_total = 0;
  int        cyc = 0;
  int        go_cyc = 0;
  int        starts_seen = 0;
  int        done_seen = 0;
  int        done_cyc = 0;
  int        gap_after[1024];
  bit        stale = 1'b0;
  bit        hang_en = 1'b0;
  int        hang_idx = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model of `main`: clears finish when it sees start, raises it FinDelay
  // cycles after start falls; never answers hang_idx; stale mode holds it high.
  initial begin : main_model
    bit armed;
    int wcnt;
    int cur;
    armed = 1'b0;
    wcnt = 0;
    cur = 0;
    bus.finish = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        armed = 1'b0;
        bus.finish = 1'b0;
      end else if (stale) begin
        bus.finish = 1'b1;
      end else if (bus.start) begin
        bus.finish = 1'b0;
        armed = 1'b1;
        wcnt = 0;
        cur = int'(bus.file_index);
      end else if (armed) begin
        wcnt++;
        if (wcnt >= FinDelay) begin
          armed = 1'b0;
          if (!(hang_en && cur == hang_idx)) bus.finish = 1'b1;
        end
      end
    end
  end

  // Monitor: start pulses (index, width, gap before next job) and done pulses.
  bit in_pulse = 1'b0;
  bit gap_valid = 1'b0;
  int width = 0;
  int gap = 0;
  int cur_idx = 0;
  int prev_idx = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_pulse = 1'b0;
      gap_valid = 1'b0;
      width = 0;
    end else begin
      if (bus.start) begin
        if (!in_pulse) begin
          if (gap_valid) gap_after[prev_idx] = gap;
          gap_valid = 1'b0;
          starts_seen++;
          if (exp_idx_q.size() == 0) begin
            check("unexpected_start", 64'(bus.file_index), 64'(1024));
          end else begin
            int e;
            e = exp_idx_q.pop_front();
            check("start_index", 64'(bus.file_index), 64'(e));
          end
          in_pulse = 1'b1;
          width = 1;
          cur_idx = int'(bus.file_index);
        end else begin
          width++;
        end
      end else begin
        if (in_pulse) begin
          check("start_width", 64'(width), 64'(StartCycles));
          in_pulse = 1'b0;
          prev_idx = cur_idx;
          gap = 1;
          gap_valid = 1'b1;
        end else if (gap_valid) begin
          gap++;
        end
      end
      if (bus.done) begin
        done_seen++;
        done_cyc = cyc;
        gap_valid = 1'b0;
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'(0));
        end else begin
          done_exp_t d;
          d = exp_done_q.pop_front();
          check("done_jobs_done", 64'(bus.jobs_done), 64'(d.jobs));
          check("done_jobs_timed_out", 64'(bus.jobs_timed_out), 64'(d.tos));
          check("done_timeout_err", 64'(bus.timeout_err), 64'(d.err));
          check("done_busy_low", 64'(bus.busy), 64'(0));
        end
      end
    end
  end

  task automatic push_batch(input int first, input int last, input int jobs, input int tos,
                            input int err);
    done_exp_t d;
    for (int i = first; i <= last; i++) exp_idx_q.push_back(i);
    d.jobs = jobs;
    d.tos = tos;
    d.err = err;
    exp_done_q.push_back(d);
  endtask

  task automatic launch(input int first, input int last);
    @(posedge clk);
    #1;
    bus.first_index = IdxW'(first);
    bus.last_index = IdxW'(last);
    bus.go = 1'b1;
    go_cyc = cyc;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base, input int budget);
    int n;
    n = 0;
    while (done_seen == base && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(done_seen - base), 64'(1));
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (starts_seen < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(starts_seen), 64'(target));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base_d;
    int base_s;
    int n;
    rst = 1'b1;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    bus.first_index = '0;
    bus.last_index = '0;
    for (int i = 0; i < 1024; i++) gap_after[i] = -1;

    // Reset state
    #13;
    check("rst_start", 64'(bus.start), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_file_index", 64'(bus.file_index), 64'(0));
    check("rst_jobs_done", 64'(bus.jobs_done), 64'(0));
    check("rst_jobs_timed_out", 64'(bus.jobs_timed_out), 64'(0));
    check("rst_timeout_err", 64'(bus.timeout_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal batch 0..6
    base_d = done_seen;
    push_batch(0, 6, 7, 0, 0);
    launch(0, 6);
    check("nom_busy", 64'(bus.busy), 64'(1));
    wait_done("nom_done", base_d, 2000);
    repeat (5) @(posedge clk);
    #1;
    check("nom_single_done", 64'(done_seen - base_d), 64'(1));
    check("nom_all_starts", 64'(exp_idx_q.size()), 64'(0));

    // Stale finish held high through LAUNCH: each WAIT lasts one cycle
    stale = 1'b1;
    repeat (2) @(posedge clk);
    base_d = done_seen;
    push_batch(10, 12, 3, 0, 0);
    launch(10, 12);
    wait_done("stale_done", base_d, 500);
    check("stale_wait_10", 64'(gap_after[10]), 64'(1));
    check("stale_wait_11", 64'(gap_after[11]), 64'(1));
    stale = 1'b0;

    // Timeout on index 3 of 2..4
    hang_en = 1'b1;
    hang_idx = 3;
    base_d = done_seen;
    push_batch(2, 4, 2, 1, 1);
    launch(2, 4);
    wait_done("to_done", base_d, 2000);
    check("to_wait_len", 64'(gap_after[3]), 64'(Timeout));
    repeat (2) @(posedge clk);
    #1;
    check("to_err_sticky", 64'(bus.timeout_err), 64'(1));
    hang_en = 1'b0;

    // Top-of-range single job
    base_d = done_seen;
    push_batch(1023, 1023, 1, 0, 0);
    launch(1023, 1023);
    wait_done("top_done", base_d, 500);
    check("top_index_held", 64'(bus.file_index), 64'(1023));
    check("top_all_starts", 64'(exp_idx_q.size()), 64'(0));

    // Empty batch
    base_d = done_seen;
    push_batch(5, 2, 0, 0, 0);
    launch(5, 2);
    wait_done("empty_done", base_d, 50);
    check("empty_done_latency", 64'(done_cyc - go_cyc), 64'(2));
    check("empty_index_held", 64'(bus.file_index), 64'(1023));

    // Abort during WAIT of the second job
    base_d = done_seen;
    base_s = starts_seen;
    exp_idx_q.push_back(0);
    exp_idx_q.push_back(1);
    launch(0, 6);
    wait_starts("abort_second_start", base_s + 2, 500);
    n = 0;
    while (bus.start && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_start", 64'(bus.start), 64'(0));
    check("abort_jobs_done", 64'(bus.jobs_done), 64'(1));
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_seen), 64'(base_d));
    check("abort_no_more_starts", 64'(starts_seen), 64'(base_s + 2));

    // Asynchronous reset in the second job's LAUNCH
    base_s = starts_seen;
    for (int i = 0; i <= 6; i++) exp_idx_q.push_back(i);
    launch(0, 6);
    wait_starts("rst_second_start", base_s + 2, 500);
    #1;
    check("pre_rst_start", 64'(bus.start), 64'(1));
    check("pre_rst_jobs_done", 64'(bus.jobs_done), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_start", 64'(bus.start), 64'(0));
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_jobs_done", 64'(bus.jobs_done), 64'(0));
    check("async_rst_done", 64'(bus.done), 64'(0));
    check("async_rst_no_pending_done", 64'(exp_done_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_idx_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(bus.busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
